// File: rtl/serial_rx.sv
// Serial word receiver for the divider/shift-register link: samples s_data on
// synchronized s_clk rising edges while s_cs_n is low, presents words hold-until-read.
module serial_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  s_clk,
  input  logic                  s_data,
  input  logic                  s_cs_n,
  input  logic                  rx_read,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  framing_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_SAT   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [2:0]            sclk_sync;
  logic [2:0]            data_sync;
  logic [2:0]            cs_sync;
  logic                  edge_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  cs_q;
  logic                  data_q;
  logic                  accept;

  // Registered edge pulse lines up with the third data/cs stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_sync <= '0;
      data_sync <= '0;
      cs_sync   <= '1;
      edge_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], s_clk};
      data_sync <= {data_sync[1:0], s_data};
      cs_sync   <= {cs_sync[1:0], s_cs_n};
      edge_q    <= sclk_sync[1] & ~sclk_sync[2];
    end
  end

  always_comb begin
    cs_q      = cs_sync[2];
    data_q    = data_sync[2];
    accept    = edge_q & ~cs_q;
    word_next = {shreg, data_q};
  end

  assign busy = (bit_cnt != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      to_cnt        <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      overrun       <= 1'b0;
      framing_error <= 1'b0;

      if (rx_read && rx_valid)
        rx_valid <= 1'b0;

      if (state == IDLE) begin
        if (!cs_q)
          state <= SHIFT;
      end else if (cs_q) begin
        state   <= IDLE;
        bit_cnt <= '0;
        to_cnt  <= '0;
        if (bit_cnt != '0)
          framing_error <= 1'b1;
      end

      // accept implies cs low, so it never collides with the frame-end branch
      if (accept) begin
        shreg  <= word_next[DATA_WIDTH-2:0];
        to_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (!rx_valid || rx_read) begin
            rx_data  <= word_next;
            rx_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (!cs_q && bit_cnt != '0) begin
        if (to_cnt == TO_LAST) begin
          framing_error <= 1'b1;
          bit_cnt       <= '0;
          to_cnt        <= TO_SAT;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule
